// File: rtl/add_byte_seq.sv
// rtl/add_byte_seq.sv - multi-byte add sequencer driving an external 8-bit adder LSB-first
// Carry between bytes is rebuilt from operand MSBs and the returned sum MSB.
module add_byte_seq #(
  parameter int NBYTES = 4,
  localparam int W = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic [7:0]   add_a,
  output logic [7:0]   add_b,
  output logic         add_cin,
  input  logic [7:0]   add_sum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [2:0]     idx;
  logic           carry_q;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [W-9:0]   shadow;

  logic [5:0]     base;
  logic [7:0]     cur_a;
  logic [7:0]     cur_b;
  logic           carry_nxt;
  logic           last;

  assign base = {idx, 3'b000};
  assign last = (idx == 3'(NBYTES - 1));

  always_comb begin
    cur_a     = a_reg[base +: 8];
    cur_b     = b_reg[base +: 8];
    carry_nxt = (cur_a[7] & cur_b[7]) | ((cur_a[7] | cur_b[7]) & ~add_sum[7]);
    add_a     = 8'h00;
    add_b     = 8'h00;
    add_cin   = 1'b0;
    if (state == RUN) begin
      add_a   = cur_a;
      add_b   = cur_b;
      add_cin = carry_q;
    end
  end

  // The top byte goes straight from add_sum into result, so shadow holds only the lower bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      idx       <= 3'd0;
      carry_q   <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      shadow    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg   <= op_a;
            b_reg   <= op_b;
            carry_q <= cin;
            idx     <= 3'd0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          carry_q <= carry_nxt;
          idx     <= idx + 3'd1;
          if (last) begin
            result    <= {add_sum, shadow};
            carry_out <= carry_nxt;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            shadow[base +: 8] <= add_sum;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_byte_seq.sv
// tb/tb_add_byte_seq.sv - directed vector bench for add_byte_seq with behavioural 8-bit adder
module tb_add_byte_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        cin = 1'b0;
  logic        busy, done, carry_out, add_cin;
  logic [31:0] result;
  logic [7:0]  add_a, add_b, add_sum;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign add_sum = add_a + add_b + {7'd0, add_cin};

  add_byte_seq #(.NBYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic [31:0] exp_res;
    logic        exp_c;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                        output logic [31:0] res, output logic co, output int lat,
                        output logic held_ok);
    logic [31:0] prev;
    prev = result;
    held_ok = 1'b1;
    @(negedge clk);
    op_a = a; op_b = b; cin = c; start = 1'b1;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (done) break;
      if (result !== prev) held_ok = 1'b0;
    end
    res = result;
    co = carry_out;
  endtask

  initial begin
    logic [31:0] r;
    logic        co, held;
    int          lat, dcnt, since, nd;
    logic        saw5, prev_busy, sel;

    vecs[0] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
    vecs[2] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
    vecs[3] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[5] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    vecs[6] = '{32'hDEADBEEF, 32'h01010101, 1'b0, 32'hDFAEBFF0, 1'b0};

    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_add", {add_a, add_b, add_cin, carry_out}, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, r, co, lat, held);
      chk($sformatf("vec%0d_result", i), r, vecs[i].exp_res);
      chk($sformatf("vec%0d_carry", i), co, vecs[i].exp_c);
      chk($sformatf("vec%0d_latency", i), lat, 5);
      chk($sformatf("vec%0d_busy_at_done", i), busy, 0);
      chk($sformatf("vec%0d_held", i), held, 1);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), done, 0);
      chk($sformatf("vec%0d_result_hold", i), result, vecs[i].exp_res);
    end

    // start while busy: second request must be ignored entirely
    op_a = 32'd1; op_b = 32'd1; cin = 1'b0; start = 1'b1;
    dcnt = 0; saw5 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (add_a == 8'h05) saw5 = 1'b1;
      if (done) dcnt++;
      if (i == 1) begin op_a = 32'd5; op_b = 32'd5; start = 1'b1; end
      else start = 1'b0;
    end
    chk("busy_start_result", result, 32'h2);
    chk("busy_start_done_count", dcnt, 1);
    chk("busy_start_no_05", saw5, 0);

    // reset asserted on the third RUN cycle
    op_a = 32'h11111111; op_b = 32'h22222222; cin = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrun_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_busy_done", {busy, done}, 0);
    chk("midrun_rst_result", result, 0);
    chk("midrun_rst_carry", carry_out, 0);
    chk("midrun_rst_add", {add_a, add_b, add_cin}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd3, 32'd4, 1'b0, r, co, lat, held);
    chk("after_rst_result", r, 32'h7);
    chk("after_rst_carry", co, 0);
    chk("after_rst_latency", lat, 5);

    // back-to-back with start held high, alternating operand sets
    @(negedge clk);
    sel = 1'b0;
    op_a = 32'h12345678; op_b = 32'h9ABCDEF0; cin = 1'b0; start = 1'b1;
    prev_busy = 1'b0; nd = 0; since = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      since++;
      if (busy && !prev_busy) begin
        sel = ~sel;
        if (sel) begin op_a = 32'hFFFFFFFF; op_b = 32'h00000001; cin = 1'b1; end
        else     begin op_a = 32'h12345678; op_b = 32'h9ABCDEF0; cin = 1'b0; end
      end
      prev_busy = busy;
      if (done) begin
        chk($sformatf("b2b%0d_interval", nd), since, 5);
        chk($sformatf("b2b%0d_result", nd), result, nd[0] ? 32'h00000001 : 32'hACF13568);
        chk($sformatf("b2b%0d_carry", nd), carry_out, nd[0] ? 1'b1 : 1'b0);
        nd++;
        since = 0;
      end else if (nd > 0 && since == 3) begin
        chk($sformatf("b2b%0d_held", nd), result, nd[0] ? 32'hACF13568 : 32'h00000001);
      end
    end
    start = 1'b0;
    chk("b2b_done_count", nd, 6);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_idle_after", {busy, done}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
